// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: ball sequencer for the 8-LED Pong playfield.
// It turns the two player buttons into serves, returns and faults, and it
// keeps both scores and the game result for the display path.
module pong_game_ctrl #(
  parameter int STEP_CYCLES = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       b,
  input  logic       p,
  output logic [7:0] LightOut,
  output logic [3:0] ScoreB,
  output logic [3:0] ScoreP,
  output logic [1:0] Winner,
  output logic [2:0] State
);

  localparam int            CW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE_R = 3'd1,
    S_MOVE_L = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  // Button synchroniser stage and one-cycle delay for edge detection
  logic b_q, b_qd, p_q, p_qd;
  logic rb, rp;

  state_t        state_q, state_d;
  logic [7:0]    light_q, light_d;
  logic [3:0]    score_b_q, score_b_d;
  logic [3:0]    score_p_q, score_p_d;
  logic [1:0]    winner_q, winner_d;
  logic          server_q, server_d;   // 0 = b serves, 1 = p serves
  logic          scorer_q, scorer_d;   // 0 = b took the point, 1 = p
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_done;

  // Register the raw buttons once, then delay once more for rise detection
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      b_q  <= 1'b0;
      b_qd <= 1'b0;
      p_q  <= 1'b0;
      p_qd <= 1'b0;
    end else begin
      b_q  <= b;
      b_qd <= b_q;
      p_q  <= p;
      p_qd <= p_q;
    end
  end

  assign rb = b_q & ~b_qd;
  assign rp = p_q & ~p_qd;
  assign step_done = (cnt_q == CNT_LAST);

  // Game state register; reset abandons any rally or point in progress
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      light_q   <= 8'h00;
      score_b_q <= 4'd0;
      score_p_q <= 4'd0;
      winner_q  <= 2'b00;
      server_q  <= 1'b0;
      scorer_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      light_q   <= light_d;
      score_b_q <= score_b_d;
      score_p_q <= score_p_d;
      winner_q  <= winner_d;
      server_q  <= server_d;
      scorer_q  <= scorer_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: ball movement, hit windows, scoring and game end
  always_comb begin
    state_d   = state_q;
    light_d   = light_q;
    score_b_d = score_b_q;
    score_p_d = score_p_q;
    winner_d  = winner_q;
    server_d  = server_q;
    scorer_d  = scorer_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        light_d = 8'h00;
        cnt_d   = '0;
        if (!server_q && rb) begin
          light_d = 8'h80;
          state_d = S_MOVE_R;
        end else if (server_q && rp) begin
          light_d = 8'h01;
          state_d = S_MOVE_L;
        end
      end

      // Ball heading for p; only p's button matters here
      S_MOVE_R: begin
        cnt_d = step_done ? '0 : cnt_q + CW'(1);
        if (rp) begin
          cnt_d = '0;
          if (light_q == 8'h01) begin
            light_d = 8'h02;
            state_d = S_MOVE_L;
          end else begin
            light_d   = 8'hFF;
            state_d   = S_POINT;
            scorer_d  = 1'b0;
            score_b_d = score_b_q + 4'd1;
          end
        end else if (step_done) begin
          if (light_q == 8'h01) begin
            light_d   = 8'hFF;
            state_d   = S_POINT;
            scorer_d  = 1'b0;
            score_b_d = score_b_q + 4'd1;
          end else begin
            light_d = light_q >> 1;
          end
        end
      end

      // Ball heading for b; only b's button matters here
      S_MOVE_L: begin
        cnt_d = step_done ? '0 : cnt_q + CW'(1);
        if (rb) begin
          cnt_d = '0;
          if (light_q == 8'h80) begin
            light_d = 8'h40;
            state_d = S_MOVE_R;
          end else begin
            light_d   = 8'hFF;
            state_d   = S_POINT;
            scorer_d  = 1'b1;
            score_p_d = score_p_q + 4'd1;
          end
        end else if (step_done) begin
          if (light_q == 8'h80) begin
            light_d   = 8'hFF;
            state_d   = S_POINT;
            scorer_d  = 1'b1;
            score_p_d = score_p_q + 4'd1;
          end else begin
            light_d = light_q << 1;
          end
        end
      end

      // Flash the field, then either end the game or hand the serve to the loser
      S_POINT: begin
        light_d = 8'hFF;
        cnt_d   = cnt_q + CW'(1);
        if (step_done) begin
          cnt_d = '0;
          if ((scorer_q ? score_p_q : score_b_q) == WIN) begin
            state_d  = S_OVER;
            winner_d = scorer_q ? 2'b10 : 2'b01;
            light_d  = scorer_q ? 8'h0F : 8'hF0;
          end else begin
            state_d  = S_IDLE;
            light_d  = 8'h00;
            server_d = ~scorer_q;
          end
        end
      end

      S_OVER: begin
        cnt_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        light_d = 8'h00;
        cnt_d   = '0;
      end
    endcase
  end

  assign LightOut = light_q;
  assign ScoreB   = score_b_q;
  assign ScoreP   = score_p_q;
  assign Winner   = winner_q;
  assign State    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with STEP_CYCLES = 4, WIN_SCORE = 3.
module tb_pong_game_ctrl;

  logic       Clk;
  logic       Rst;
  logic       b;
  logic       p;
  logic [7:0] LightOut;
  logic [3:0] ScoreB;
  logic [3:0] ScoreP;
  logic [1:0] Winner;
  logic [2:0] State;

  int vectors;
  int miscompares;

  pong_game_ctrl #(.STEP_CYCLES(4), .WIN_SCORE(3)) dut (
    .Clk(Clk), .Rst(Rst), .b(b), .p(p),
    .LightOut(LightOut), .ScoreB(ScoreB), .ScoreP(ScoreP),
    .Winner(Winner), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n clock edges, landing on the falling edge after the last one
  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ls(input string tag, input logic [7:0] l, input logic [2:0] s);
    chk({tag, ".light"}, LightOut, l);
    chk({tag, ".state"}, {5'd0, State}, {5'd0, s});
  endtask

  task automatic chk_all(input string tag, input logic [7:0] l, input logic [3:0] sb,
                         input logic [3:0] sp, input logic [1:0] w, input logic [2:0] s);
    chk_ls(tag, l, s);
    chk({tag, ".scoreb"}, {4'd0, ScoreB}, {4'd0, sb});
    chk({tag, ".scorep"}, {4'd0, ScoreP}, {4'd0, sp});
    chk({tag, ".winner"}, {6'd0, Winner}, {6'd0, w});
  endtask

  // Pulse for one sampling edge; returns just after the edge that acts on it
  task automatic press_b();
    b = 1'b1; step(1); b = 1'b0; step(1);
  endtask

  task automatic press_p();
    p = 1'b1; step(1); p = 1'b0; step(1);
  endtask

  // Follow the ball for n shifts, checking each new position after 4 cycles
  task automatic travel(input string tag, input logic [7:0] start, input bit right, input int n);
    logic [7:0] pos;
    pos = start;
    for (int i = 0; i < n; i++) begin
      pos = right ? (pos >> 1) : (pos << 1);
      step(4);
      chk_ls(tag, pos, right ? 3'd1 : 3'd2);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Rst = 1'b0; b = 1'b0; p = 1'b0;

    // 1. reset state, then non-server press ignored
    step(3);
    chk_all("reset", 8'h00, 4'd0, 4'd0, 2'b00, 3'd0);
    Rst = 1'b1;
    step(1);
    press_p();
    chk_ls("idle_p_ignored", 8'h00, 3'd0);
    step(1);

    // 2. serve by b, full traverse, return by p
    press_b();
    chk_ls("serve_b", 8'h80, 3'd1);
    travel("rally1", 8'h80, 1'b1, 7);
    press_p();
    chk_ls("return_p", 8'h02, 3'd2);
    travel("rally1_back", 8'h02, 1'b0, 6);
    // b rises so it is detected in the last window cycle: still a return
    step(2);
    b = 1'b1; step(1); b = 1'b0; step(1);
    chk_ls("return_b_last_cycle", 8'h40, 3'd1);

    // 3. p misses
    travel("rally1_out", 8'h40, 1'b1, 6);
    step(3);
    chk_ls("window_last_cycle", 8'h01, 3'd1);
    step(1);
    chk_all("miss_point", 8'hFF, 4'd1, 4'd0, 2'b00, 3'd3);
    step(3);
    chk_ls("point_held", 8'hFF, 3'd3);
    step(1);
    chk_all("point_to_idle", 8'h00, 4'd1, 4'd0, 2'b00, 3'd0);
    press_b();
    chk_ls("idle_b_ignored", 8'h00, 3'd0);
    press_p();
    chk_ls("serve_p", 8'h01, 3'd2);
    // rp during MOVE_L ignored, then early rb is a fault
    step(1);
    press_p();
    step(1);
    chk_ls("move_l_p_ignored", 8'h02, 3'd2);
    press_b();
    chk_all("fault_b", 8'hFF, 4'd1, 4'd1, 2'b00, 3'd3);
    step(4);
    chk_ls("fault_to_idle", 8'h00, 3'd0);

    // 4. early press by p at 08
    press_b();
    chk_ls("serve_b2", 8'h80, 3'd1);
    travel("rally2", 8'h80, 1'b1, 4);
    press_p();
    chk_all("early_p", 8'hFF, 4'd2, 4'd1, 2'b00, 3'd3);
    step(4);
    chk_ls("early_to_idle", 8'h00, 3'd0);
    // p serves and b misses
    press_p();
    chk_ls("serve_p2", 8'h01, 3'd2);
    travel("rally3", 8'h01, 1'b0, 7);
    step(4);
    chk_all("miss_b", 8'hFF, 4'd2, 4'd2, 2'b00, 3'd3);
    step(4);
    chk_ls("miss_b_idle", 8'h00, 3'd0);
    // b serves; rb during MOVE_R ignored; simultaneous rises at 01 still return
    press_b();
    chk_ls("serve_b3", 8'h80, 3'd1);
    step(1);
    press_b();
    step(1);
    chk_ls("move_r_b_ignored", 8'h40, 3'd1);
    travel("rally4", 8'h40, 1'b1, 6);
    b = 1'b1; p = 1'b1; step(1); b = 1'b0; p = 1'b0; step(1);
    chk_ls("simul_return", 8'h02, 3'd2);
    travel("rally4_back", 8'h02, 1'b0, 6);
    press_b();
    chk_ls("return_b", 8'h40, 3'd1);
    travel("rally4_out", 8'h40, 1'b1, 6);

    // 5. third point for b ends the game
    step(4);
    chk_all("final_point", 8'hFF, 4'd3, 4'd2, 2'b00, 3'd3);
    step(4);
    chk_all("game_over", 8'hF0, 4'd3, 4'd2, 2'b01, 3'd4);
    b = 1'b1; p = 1'b1; step(1); b = 1'b0; p = 1'b0; step(3);
    chk_all("over_ignores", 8'hF0, 4'd3, 4'd2, 2'b01, 3'd4);
    Rst = 1'b0;
    step(1);
    chk_all("over_reset", 8'h00, 4'd0, 4'd0, 2'b00, 3'd0);
    Rst = 1'b1;
    step(1);

    // 6. reset mid-rally
    press_b();
    chk_ls("serve_b4", 8'h80, 3'd1);
    travel("rally5", 8'h80, 1'b1, 3);
    Rst = 1'b0;
    step(1);
    chk_all("mid_rally_reset", 8'h00, 4'd0, 4'd0, 2'b00, 3'd0);
    Rst = 1'b1;
    press_p();
    chk_ls("post_reset_p_ignored", 8'h00, 3'd0);
    press_b();
    chk_ls("post_reset_serve_b", 8'h80, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
